// File: rtl/pe_eject_nic.sv
// pe_eject_nic: router ejection-port receive NIC; header check, FWFT FIFO to the PE, saturating stats.
module pe_eject_nic #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic             peso,
  input  logic [63:0]      pedo,
  output logic             pero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_src,
  output logic [31:0]      out_payload,
  output logic             out_vc,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             vc_mis
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [49:0] mem_q [DEPTH];
  logic [49:0] mem_d [DEPTH];
  logic [49:0] hold_q, hold_d, head, entry;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rx_q, rx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic vcm_q, vcm_d, push, pop;
  // hold_q keeps the last popped entry so out_* stay stable while empty
  always_comb begin
    pero = cnt_q != FULL;
    out_valid = cnt_q != '0;
    push = peso & pero;
    pop = out_valid & out_ready;
    entry = {(|pedo[55:48]) | (|pedo[60:56]), pedo[63], pedo[47:32], pedo[31:0]};
    head = out_valid ? mem_q[rp_q] : hold_q;
    mem_d = mem_q;
    if (push) mem_d[wp_q] = entry;
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    hold_d = pop ? head : hold_q;
    rx_d = cnt_clr ? '0 : (push && !(&rx_q)) ? rx_q + CNT_W'(1) : rx_q;
    err_d = cnt_clr ? '0 : (push && entry[49] && !(&err_q)) ? err_q + ERR_W'(1) : err_q;
    vcm_d = !cnt_clr && (vcm_q || (push && pedo[63] != polarity));
    {out_err, out_vc, out_src, out_payload} = head;
    rx_cnt = rx_q;
    err_cnt = err_q;
    vc_mis = vcm_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      hold_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rx_q <= '0;
      err_q <= '0;
      vcm_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      hold_q <= hold_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      err_q <= err_d;
      vcm_q <= vcm_d;
    end
  end
endmodule

// File: tb/tb_pe_eject_nic.sv
// tb_pe_eject_nic: scoreboard bench for pe_eject_nic plus a CNT_W=4 twin for counter saturation.
module tb_pe_eject_nic;
  logic clk = 1'b0, reset = 1'b0, polarity = 1'b0, peso = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [63:0] pedo = '0;
  logic pero, out_valid, out_vc, out_err, vc_mis;
  logic [15:0] out_src, rx_cnt;
  logic [31:0] out_payload;
  logic [7:0] err_cnt;
  logic s_pero, s_valid, s_vc, s_err, s_vcm;
  logic [15:0] s_src;
  logic [31:0] s_pay;
  logic [3:0] s_rx;
  logic [7:0] s_errc;
  int checks = 0, errors = 0;
  logic [49:0] q[$];
  logic [49:0] last = '0;
  logic [15:0] mrx = '0;
  logic [7:0] merr = '0;
  logic [3:0] msat = '0;
  logic mvcm = 1'b0, push_m, pop_m;

  pe_eject_nic dut (
    .clk(clk), .reset(reset), .polarity(polarity), .peso(peso), .pedo(pedo), .pero(pero),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_payload(out_payload),
    .out_vc(out_vc), .out_err(out_err), .cnt_clr(cnt_clr), .rx_cnt(rx_cnt), .err_cnt(err_cnt),
    .vc_mis(vc_mis));

  pe_eject_nic #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .polarity(polarity), .peso(peso), .pedo(pedo), .pero(s_pero),
    .out_valid(s_valid), .out_ready(out_ready), .out_src(s_src), .out_payload(s_pay),
    .out_vc(s_vc), .out_err(s_err), .cnt_clr(cnt_clr), .rx_cnt(s_rx), .err_cnt(s_errc),
    .vc_mis(s_vcm));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [49:0] ent(input logic [63:0] p);
    return {(p[55:48] != 8'h00) || (p[60:56] != 5'b0), p[63], p[47:32], p[31:0]};
  endfunction

  function automatic logic [63:0] mk(input logic vc, input logic [7:0] hop, input logic [15:0] src,
                                     input logic [31:0] pay);
    return {vc, 2'b01, 5'b0, hop, src, pay};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] p);
    logic acc;
    int n;
    peso = 1'b1;
    pedo = p;
    n = 0;
    do begin
      acc = pero;
      cyc(1);
      n++;
    end while (!acc && n < 40);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    peso = 1'b0;
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
  endtask

  // Reference model: expectations for the upcoming edge are formed from inputs stable at the negedge
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      last = '0;
      mrx = '0;
      merr = '0;
      msat = '0;
      mvcm = 1'b0;
      chk("rst_pero", pero, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_head", {out_err, out_vc, out_src, out_payload}, 0);
      chk("rst_rx", rx_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_vcm", vc_mis, 0);
      chk("rst_sat", s_rx, 0);
    end else begin
      chk("pero", pero, q.size() != 4);
      chk("valid", out_valid, q.size() != 0);
      if (q.size() != 0) chk("head", {out_err, out_vc, out_src, out_payload}, q[0]);
      else chk("hold", {out_err, out_vc, out_src, out_payload}, last);
      chk("rx", rx_cnt, mrx);
      chk("errc", err_cnt, merr);
      chk("vcm", vc_mis, mvcm);
      chk("sat", s_rx, msat);
      push_m = peso && q.size() != 4;
      pop_m = out_ready && q.size() != 0;
      if (pop_m) last = q.pop_front();
      if (push_m) q.push_back(ent(pedo));
      if (cnt_clr) begin
        mrx = '0;
        merr = '0;
        msat = '0;
        mvcm = 1'b0;
      end else if (push_m) begin
        if (mrx != 16'hFFFF) mrx++;
        if (msat != 4'hF) msat++;
        if (ent(pedo) >> 49 != 0 && merr != 8'hFF) merr++;
        if (pedo[63] != polarity) mvcm = 1'b1;
      end
    end
  end

  initial begin
    cyc(2);
    chk("init_pero", pero, 1);
    chk("init_valid", out_valid, 0);
    reset = 1'b1;
    cyc(1);
    // single packet
    polarity = 1'b1;
    out_ready = 1'b1;
    send({1'b1, 2'b11, 5'b0, 8'h00, 16'h0101, 32'hAAAA_AAAA});
    chk("sp_valid", out_valid, 1);
    chk("sp_src", out_src, 16'h0101);
    chk("sp_pay", out_payload, 32'hAAAA_AAAA);
    chk("sp_vc", out_vc, 1);
    chk("sp_err", out_err, 0);
    chk("sp_rx", rx_cnt, 1);
    chk("sp_vcm", vc_mis, 0);
    cyc(2);
    // fill and backpressure
    clr();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(mk(1'b1, 8'h00, 16'h0202, {8{i[3:0]}}));
    chk("fill_pero", pero, 0);
    peso = 1'b1;
    pedo = mk(1'b1, 8'h00, 16'h0202, 32'h5555_5555);
    repeat (3) begin
      chk("held_pero", pero, 0);
      cyc(1);
    end
    out_ready = 1'b1;
    send(mk(1'b1, 8'h00, 16'h0202, 32'h5555_5555));
    cyc(6);
    chk("fill_rx", rx_cnt, 5);
    chk("fill_empty", out_valid, 0);
    chk("fill_last", out_payload, 32'h5555_5555);
    // streaming wrap
    clr();
    for (int i = 0; i < 16; i++) begin
      chk("stream_pero", pero, 1);
      send(mk(1'b1, 8'h00, 16'h0303, 32'hC000_0000 + i));
      chk("stream_lat", out_payload, 32'hC000_0000 + i);
    end
    cyc(2);
    chk("stream_rx", rx_cnt, 16);
    // header error and vc mismatch, then clear racing an error push
    clr();
    out_ready = 1'b0;
    send(mk(1'b0, 8'h11, 16'h0404, 32'hE000_0001));
    chk("he_err", out_err, 1);
    chk("he_errc", err_cnt, 1);
    chk("he_vcm", vc_mis, 1);
    cnt_clr = 1'b1;
    send(mk(1'b0, 8'h22, 16'h0404, 32'hE000_0002));
    cnt_clr = 1'b0;
    chk("clr_errc", err_cnt, 0);
    chk("clr_rx", rx_cnt, 0);
    chk("clr_vcm", vc_mis, 0);
    chk("clr_keep", out_valid, 1);
    out_ready = 1'b1;
    cyc(3);
    // reset with two entries queued
    out_ready = 1'b0;
    send(mk(1'b1, 8'h00, 16'h0505, 32'h7777_0001));
    send(mk(1'b1, 8'h00, 16'h0505, 32'h7777_0002));
    reset = 1'b0;
    #1;
    chk("ar_pero", pero, 1);
    chk("ar_valid", out_valid, 0);
    chk("ar_rx", rx_cnt, 0);
    chk("ar_pay", out_payload, 0);
    cyc(2);
    reset = 1'b1;
    out_ready = 1'b1;
    cyc(3);
    chk("ar_stale", out_valid, 0);
    // saturation on the CNT_W=4 twin, random headers exercise the error check
    clr();
    for (int i = 0; i < 20; i++) send({$urandom, $urandom});
    cyc(2);
    chk("sat_rx", s_rx, 4'hF);
    chk("main_rx20", rx_cnt, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_eject_nic.md
# pe_eject_nic

Receive-side network interface sitting between a mesh router's local ejection port (peso/pedo/pero) and the processing element. Accepts 64-bit packets from the router under a valid/ready handshake and buffers them in a small FIFO. Decodes the header and presents source ID, VC bit and payload to the PE under a second valid/ready handshake. Checks that each arriving packet has exhausted its hop count and keeps saturating receive and error statistics.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of rx_cnt.
- ERR_W, 8, width of err_cnt.

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- polarity  in  1  router VC polarity of the current cycle; sampled with each accepted packet
- peso  in  1  router has a valid packet on pedo
- pedo  in  64  packet: [63] vc, [62:61] dir, [60:56] rsvd, [55:48] hop, [47:32] src, [31:0] payload
- pero  out  1  NIC can accept a packet this cycle
- out_valid  out  1  head entry available to PE
- out_ready  in  1  PE takes head entry
- out_src  out  16  head src ({row byte, col byte})
- out_payload  out  32  head payload
- out_vc  out  1  head vc bit
- out_err  out  1  head entry failed header check
- cnt_clr  in  1  synchronous clear of rx_cnt, err_cnt, vc_mis
- rx_cnt  out  CNT_W  packets accepted, saturating
- err_cnt  out  ERR_W  packets with header error, saturating
- vc_mis  out  1  sticky: some accepted packet had vc != polarity

## Operation
- Accept: push on rising edge when peso=1 and pero=1. Router holds pedo stable while peso=1 and pero=0.
- pero = (count != DEPTH), driven combinationally from registered count only. It does not depend on peso or out_ready.
- Stored entry: {err, vc, src, payload}, 50 bits. dir and rsvd are discarded.
- err = (hop != 8'h00) | (rsvd != 5'b0).
- Pop: on rising edge when out_valid=1 and out_ready=1. out_valid = (count != 0).
- The out_* fields show the head entry (first-word fall-through from storage). When empty they hold the last popped value, or 0 since reset.
- FIFO: read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- When full, no push occurs (pero=0), even if a pop happens in the same cycle. A pop when full does not open pero until the next cycle.
- Empty with push: the entry is visible on out_* the following cycle. There is no same-cycle bypass.
- Stats per accepted packet:
  - rx_cnt increments by 1, holding at all-ones.
  - err_cnt increments when err=1, holding at all-ones.
  - vc_mis sets when pedo[63] != polarity.
- cnt_clr=1 zeroes rx_cnt, err_cnt and vc_mis. Clear takes priority over a same-cycle increment. FIFO contents are unaffected.
- reset low at any time, including mid-transfer:
  - pointers, count, stats, vc_mis and storage go to 0.
  - in-flight entries are lost.
  - Outputs go to pero=1, out_valid=0, all out_* fields 0, rx_cnt=0, err_cnt=0, vc_mis=0.
  - Outputs hold these values while reset is low.

## Timing
- Latency: packet accepted at edge N → out_valid=1 and fields valid after edge N (cycle N+1).
- Throughput: 1 packet/cycle sustained when out_ready=1 continuously. pero stays 1 and no bubbles are inserted.
- A pop at edge N shows the next head (or out_valid=0) after edge N.
- Stats update at the same edge as the push. rx_cnt reflects packet N after edge N.
- pero falls after the edge that makes count=DEPTH. It rises after the first edge with a pop while full.
- No combinational path from out_ready to pero, or from peso to out_valid.

## Test plan
- Reset/idle:
  - Stimulus: reset low mid-sim, with 2 entries queued.
  - Required: immediately pero=1, out_valid=0, rx_cnt=0, out_payload=0. After release, no stale entry appears.
- Single packet:
  - Stimulus: pedo={1'b1,2'b11,5'b0,8'h00,16'h0101,32'hAAAA_AAAA}, peso=1 for one cycle, polarity=1, out_ready=1.
  - Required next cycle: out_valid=1, out_src=16'h0101, out_payload=32'hAAAA_AAAA, out_vc=1, out_err=0, rx_cnt=1, vc_mis=0.
- Fill/backpressure:
  - Stimulus: out_ready=0, push 5 packets with payloads 32'h1111_1111..32'h5555_5555 on consecutive cycles.
  - Required: 4 accepted and pero=0 after the 4th. The 5th is held.
  - Stimulus: raise out_ready.
  - Required: pops return 1111..,2222..,3333..,4444..,5555.. in order, and rx_cnt=5.
- Streaming wrap:
  - Stimulus: 16 back-to-back packets with out_ready=1.
  - Required: pero stays 1, each payload appears exactly 1 cycle after acceptance, and rx_cnt=16.
- Header error/VC:
  - Stimulus: packet with hop=8'h11, vc=0, polarity=1.
  - Required: out_err=1, err_cnt=1, vc_mis=1.
  - Stimulus: cnt_clr pulse coincident with another error packet.
  - Required: err_cnt=0, rx_cnt=0, vc_mis=0; the FIFO still holds both entries.
- Saturation:
  - Stimulus: CNT_W=4, push 20 packets.
  - Required: rx_cnt=4'hF; it does not wrap.
